// File: rtl/ex_div_pkg.sv
// Shared EX-stage encodings for the divider: RV32M funct3 codes and bus widths.
package ex_div_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Shares the start/busy/ready/waddr handshake with the EX multiplier.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int XLEN   = REG_BUS_W,
    parameter int REG_AW = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              div_start_i,
    input  logic [XLEN-1:0]   div_dividend_i,
    input  logic [XLEN-1:0]   div_divisor_i,
    input  logic [2:0]        div_op_i,
    input  logic [REG_AW-1:0] div_reg_waddr_i,
    output logic              div_ready_o,
    output logic [XLEN-1:0]   div_res_o,
    output logic              div_busy_o,
    output logic [REG_AW-1:0] div_reg_waddr_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] CALC  = 2'd2;
    localparam logic [1:0] END   = 2'd3;

    logic [1:0]      state, next_state;
    logic            is_rem, neg_q, neg_r;
    logic [XLEN-1:0] dvd, dvs, rem;
    logic [5:0]      cnt;

    logic            op_signed, op_rem;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;
    logic            ge;

    logic            ready_d, busy_d;
    logic [XLEN-1:0] res_d;

    // Codes outside 1xx fall through as DIVU (unsigned quotient).
    assign op_signed = div_op_i[2] & ~div_op_i[0];
    assign op_rem    = div_op_i[2] & div_op_i[1];
    assign mag_a     = (op_signed && div_dividend_i[XLEN-1]) ? -div_dividend_i : div_dividend_i;
    assign mag_b     = (op_signed && div_divisor_i[XLEN-1])  ? -div_divisor_i  : div_divisor_i;

    // Shifted partial remainder can reach 2*dvs-1, so the compare carries one
    // extra bit; the top bit of the difference is the borrow.
    assign rem_sh = {rem, dvd[XLEN-1]};
    assign diff   = {1'b0, rem_sh} - {2'b00, dvs};
    assign ge     = ~diff[XLEN+1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (div_start_i) next_state = START;
            START: begin
                if (!div_start_i)   next_state = IDLE;
                else if (dvs == '0) next_state = END;
                else                next_state = CALC;
            end
            CALC: begin
                if (!div_start_i)              next_state = IDLE;
                else if (cnt == 6'(XLEN - 1))  next_state = END;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (next_state == START) || (next_state == CALC);
        ready_d = (state == END);
        if (is_rem) res_d = neg_r ? -rem : rem;
        else        res_d = neg_q ? -dvd : dvd;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            is_rem          <= 1'b0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            dvd             <= ZERO_WORD;
            dvs             <= ZERO_WORD;
            rem             <= ZERO_WORD;
            cnt             <= 6'd0;
            div_ready_o     <= 1'b0;
            div_busy_o      <= 1'b0;
            div_res_o       <= ZERO_WORD;
            div_reg_waddr_o <= '0;
        end else begin
            div_ready_o <= ready_d;
            div_busy_o  <= busy_d;
            case (state)
                IDLE: if (div_start_i) begin
                    is_rem          <= op_rem;
                    neg_q           <= op_signed & (div_dividend_i[XLEN-1] ^ div_divisor_i[XLEN-1]);
                    neg_r           <= op_signed & div_dividend_i[XLEN-1];
                    dvd             <= mag_a;
                    dvs             <= mag_b;
                    div_reg_waddr_o <= div_reg_waddr_i;
                end
                START: begin
                    if (dvs == '0) begin
                        // Divide by zero: the remainder fixup re-negates the
                        // magnitude, restoring the original dividend exactly.
                        dvd   <= '1;
                        rem   <= dvd;
                        neg_q <= 1'b0;
                    end else begin
                        rem <= ZERO_WORD;
                        cnt <= 6'd0;
                    end
                end
                CALC: begin
                    rem <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
                    dvd <= {dvd[XLEN-2:0], ge};
                    cnt <= cnt + 6'd1;
                end
                default: div_res_o <= res_d;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus random ops
// against an arithmetic RV32M reference model.
module tb_ex_div;
    import ex_div_pkg::*;

    logic        clk, rstn;
    logic        div_start_i;
    logic [31:0] div_dividend_i, div_divisor_i;
    logic [2:0]  div_op_i;
    logic [4:0]  div_reg_waddr_i;
    logic        div_ready_o;
    logic [31:0] div_res_o;
    logic        div_busy_o;
    logic [4:0]  div_reg_waddr_o;

    int errs = 0;
    int checks = 0;

    ex_div dut (
        .clk             (clk),
        .rstn            (rstn),
        .div_start_i     (div_start_i),
        .div_dividend_i  (div_dividend_i),
        .div_divisor_i   (div_divisor_i),
        .div_op_i        (div_op_i),
        .div_reg_waddr_i (div_reg_waddr_i),
        .div_ready_o     (div_ready_o),
        .div_res_o       (div_res_o),
        .div_busy_o      (div_busy_o),
        .div_reg_waddr_o (div_reg_waddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            INST_DIV:  return (b == 0) ? 32'hFFFF_FFFF :
                              (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            INST_REM:  return (b == 0) ? a :
                              (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
            INST_REMU: return (b == 0) ? a : a % b;
            default:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
        endcase
    endfunction

    // Issue one op from just after a rising edge; lat = edges from capture to ready.
    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input bit hold);
        int lat;
        div_op_i        = op;
        div_dividend_i  = a;
        div_divisor_i   = b;
        div_reg_waddr_i = rd;
        div_start_i     = 1'b1;
        lat = -1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin
                chk({tag, " busy"}, {31'd0, div_busy_o}, 32'd1);
                div_dividend_i  = $urandom;
                div_divisor_i   = $urandom;
                div_op_i        = 3'($urandom);
                div_reg_waddr_i = 5'($urandom);
            end
            if (div_ready_o) begin
                lat = n;
                break;
            end
        end
        if (!hold) div_start_i = 1'b0;
        chk({tag, " latency"}, 32'(lat), (b == 0) ? 32'd2 : 32'd34);
        chk({tag, " res"}, div_res_o, ref_res(op, a, b));
        chk({tag, " waddr"}, {27'd0, div_reg_waddr_o}, {27'd0, rd});
        chk({tag, " busy at ready"}, {31'd0, div_busy_o}, 32'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] a, b;
        logic [2:0] op;
        rstn = 1'b0;
        div_start_i = 1'b0;
        div_dividend_i = '0;
        div_divisor_i = '0;
        div_op_i = '0;
        div_reg_waddr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", {31'd0, div_ready_o}, 32'd0);
        chk("reset busy", {31'd0, div_busy_o}, 32'd0);
        chk("reset res", div_res_o, 32'd0);
        chk("reset waddr", {27'd0, div_reg_waddr_o}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        run("divu 100/7", INST_DIVU, 32'd100, 32'd7, 5'd5, 0);
        run("remu 100/7", INST_REMU, 32'd100, 32'd7, 5'd6, 0);
        run("div -7/2", INST_DIV, -32'sd7, 32'd2, 5'd7, 0);
        run("rem -7/2", INST_REM, -32'sd7, 32'd2, 5'd8, 0);
        run("rem 7/-2", INST_REM, 32'd7, -32'sd2, 5'd9, 0);
        run("div x/0", INST_DIV, 32'h1234, 32'd0, 5'd10, 0);
        run("rem x/0", INST_REM, 32'h1234, 32'd0, 5'd11, 0);
        run("divu x/0", INST_DIVU, 32'h1234, 32'd0, 5'd12, 0);
        run("rem -5/0", INST_REM, -32'sd5, 32'd0, 5'd13, 0);
        run("div ovf", INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
        run("rem ovf", INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0);
        run("divu big", INST_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 5'd16, 0);
        run("remu big", INST_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 5'd17, 0);

        // Abort: drop start while CALC holds count 10.
        div_op_i = INST_DIVU; div_dividend_i = 32'd1000; div_divisor_i = 32'd3;
        div_reg_waddr_i = 5'd20; div_start_i = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        div_start_i = 1'b0;
        @(posedge clk); #1;
        chk("abort busy", {31'd0, div_busy_o}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_ready_o) seen++;
        end
        chk("abort no ready", 32'(seen), 32'd0);
        run("divu 9/3 after abort", INST_DIVU, 32'd9, 32'd3, 5'd21, 0);

        // Back-to-back: start stays high across the ready cycle.
        run("b2b divu", INST_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd22, 1);
        run("b2b remu", INST_REMU, 32'd10, 32'd3, 5'd23, 0);

        for (int i = 0; i < 24; i++) begin
            op = 3'b100 | 3'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if (i % 5 == 0) a = 32'h8000_0000;
            run($sformatf("rand%0d", i), op, a, b, 5'($urandom), 0);
        end

        // Asynchronous reset in the middle of CALC.
        div_op_i = INST_DIVU; div_dividend_i = 32'd77; div_divisor_i = 32'd5;
        div_reg_waddr_i = 5'd30; div_start_i = 1'b1;
        repeat (15) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("midreset busy", {31'd0, div_busy_o}, 32'd0);
        chk("midreset res", div_res_o, 32'd0);
        chk("midreset waddr", {27'd0, div_reg_waddr_o}, 32'd0);
        chk("midreset ready", {31'd0, div_ready_o}, 32'd0);
        div_start_i = 1'b0;
        #2;
        rstn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_ready_o) seen++;
        end
        chk("midreset no ready", 32'(seen), 32'd0);
        run("divu after reset", INST_DIVU, 32'd77, 32'd5, 5'd31, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
